conv_viterbi_codec: RTL and testbench
=====================================

Name: conv_viterbi_codec

Overview:
Rate-1/2, constraint-length-3 convolutional encoder plus hard-decision 4-state Viterbi decoder, packaged as one block for the encoder → channel → decoder link.
- Generator polynomials are 7 and 5 (octal).
- The encoder and decoder sides are independent. The system wires the encoder output through a (possibly error-injecting) channel register into the decoder input.
- The decoder uses register-exchange survivors with fixed decision depth TB_DEPTH.

Parameters:
TB_DEPTH, 16, survivor length in symbols; decoder latency in accepted symbols (legal 4..64).
PM_W, 8, path-metric width in bits (legal ≥5).

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  reset; one clock; reset is synchronous and active-high.
enc_enable_i  in  1  encoder accepts enc_d_i this cycle.
enc_d_i  in  1  information bit to encode.
enc_valid_o  out  1  enc_d_o holds a fresh symbol.
enc_d_o  out  2  coded symbol {g7 bit, g5 bit}.
dec_enable_i  in  1  decoder accepts dec_d_i this cycle.
dec_d_i  in  2  received hard-decision symbol, same bit order as enc_d_o.
dec_valid_o  out  1  dec_d_o holds a fresh decoded bit.
dec_d_o  out  1  decoded information bit.

Behaviour:

Encoder:
- State register s[1:0] = {b(k-2), b(k-1)}; reset value 0.
- When enc_enable_i=1, on the clock edge with u=enc_d_i:
  - enc_d_o <= {u^s[0]^s[1], u^s[1]};
  - s <= {s[0], u}.
- enc_valid_o <= enc_enable_i.
- When disabled, enc_d_o and s hold. Latency is 1 cycle.

Decoder trellis:
- State {a,b} with input u goes to next state {b,u}.
- Expected symbol on that branch is {u^b^a, u^a}.
- Predecessors of next state {b,u} are {0,b} and {1,b}.

Decoder, per accepted symbol r=dec_d_i:
- Branch metric = Hamming distance(r, expected), 0..2.
- ACS: candidate = PM[pred] + BM. Choose the smaller candidate; on a tie, choose pred {0,b}.
- Normalisation: subtract the minimum of the four new metrics from all four, so the minimum metric is always 0. Saturate at 2^PM_W−1.
- Survivor update: surv[ns] <= {surv[pred][TB_DEPTH-2:0], u}, where u = LSB of ns.
- Best state = the one with minimum new metric; on a tie, the lowest index.
- dec_d_o <= surv_new[best][TB_DEPTH-1], the oldest bit.
- Fill counter counts accepted symbols and saturates at TB_DEPTH.
- dec_valid_o <= 1 for one cycle after an accepted symbol if the count (including this symbol) ≥ TB_DEPTH; otherwise 0.

Decoder latency and enable:
- The bit for symbol j appears on dec_d_o in the cycle after symbol j+TB_DEPTH−1 is accepted, i.e. TB_DEPTH cycles after symbol j under continuous enable.
- dec_enable_i=0: metrics, survivors, counter and dec_d_o hold; dec_valid_o=0.

Reset values:
- PM[0]=0; PM[1..3]=4 (start-in-zero-state bias).
- Survivors, counter, dec_d_o, dec_valid_o, enc_d_o, enc_valid_o, s all 0.
- Reset mid-stream discards all history and restarts the fill count.
- Reset dominates enable in the same cycle.

Correction capability:
- The code has free distance 5.
- Any single channel bit error per ≥8-symbol window is corrected, given TB_DEPTH ≥ 15.

Test Plan:
1. Encoder vector: reset, then encode 1,0,1,1,0,0 → enc_d_o = 11,10,00,01,01,11; enc_valid_o is high 1 cycle after each enable.
2. Clean loopback: 256 random bits, encoder output registered into the decoder, continuous enable → dec_d_o equals input delayed TB_DEPTH symbols, zero mismatches; dec_valid_o first rises after 16 symbols.
3. Periodic single error: flip bit 1 of every 8th symbol over 256 symbols → zero decoded-bit mismatches.
4. Enable gaps: random dec_enable_i/enc_enable_i deassertion with matched gaps → outputs hold during gaps, decoded stream still error-free, dec_valid_o never high in a gap cycle.
5. All-zero input with symbol 11 injected once → decoded bits all 0; metric normalisation keeps min PM = 0.
6. Reset asserted mid-stream (cycle 100) then restart → dec_valid_o is low for the next 15 accepted symbols and the new stream decodes correctly.

Source files
------------

// File: rtl/conv_viterbi_codec.sv
// conv_viterbi_codec: rate-1/2 K=3 (7,5) convolutional encoder and
// hard-decision 4-state register-exchange Viterbi decoder.
module conv_viterbi_codec #(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_enable_i,
   input  logic       enc_d_i,
   output logic       enc_valid_o,
   output logic [1:0] enc_d_o,
   input  logic       dec_enable_i,
   input  logic [1:0] dec_d_i,
   output logic       dec_valid_o,
   output logic       dec_d_o
);
   localparam int CNT_W = $clog2(TB_DEPTH + 1);
   localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};
   localparam logic [CNT_W-1:0] FULL = CNT_W'(TB_DEPTH);

   logic [1:0]          s_q;
   logic [PM_W-1:0]     pm_q [4];
   logic [PM_W-1:0]     pm_d [4];
   logic [TB_DEPTH-1:0] surv_q [4];
   logic [TB_DEPTH-1:0] surv_d [4];
   logic [PM_W:0]       acc [4];
   logic [PM_W:0]       acc_min, c0, c1, d;
   logic [TB_DEPTH-1:0] sp;
   logic [1:0]          p0, p1, best;
   logic                u;
   logic [CNT_W-1:0]    cnt_q;

   function automatic logic [1:0] hd(input logic [1:0] x);
      return {x[1] & x[0], x[1] ^ x[0]};
   endfunction

   function automatic logic [1:0] branch_sym(input logic [1:0] p, input logic u_i);
      return {u_i ^ p[0] ^ p[1], u_i ^ p[1]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q         <= '0;
         enc_d_o     <= '0;
         enc_valid_o <= 1'b0;
      end else begin
         enc_valid_o <= enc_enable_i;
         if (enc_enable_i) begin
            enc_d_o <= {enc_d_i ^ s_q[0] ^ s_q[1], enc_d_i ^ s_q[1]};
            s_q     <= {s_q[0], enc_d_i};
         end
      end
   end

   // Next state n={b,u} is reached from predecessors {0,b} and {1,b}; ties go to {0,b}.
   always_comb begin
      p0      = '0;
      p1      = '0;
      u       = 1'b0;
      c0      = '0;
      c1      = '0;
      d       = '0;
      sp      = '0;
      best    = '0;
      acc_min = '1;
      acc     = '{default: '0};
      surv_d  = '{default: '0};
      pm_d    = '{default: '0};
      for (int n = 0; n < 4; n++) begin
         p0 = 2'(n >> 1);
         p1 = p0 | 2'b10;
         u  = 1'(n);
         c0 = {1'b0, pm_q[p0]} + {{(PM_W-1){1'b0}}, hd(dec_d_i ^ branch_sym(p0, u))};
         c1 = {1'b0, pm_q[p1]} + {{(PM_W-1){1'b0}}, hd(dec_d_i ^ branch_sym(p1, u))};
         acc[n]    = (c1 < c0) ? c1 : c0;
         sp        = (c1 < c0) ? surv_q[p1] : surv_q[p0];
         surv_d[n] = {sp[TB_DEPTH-2:0], u};
         if (acc[n] < acc_min) begin
            acc_min = acc[n];
            best    = 2'(n);
         end
      end
      for (int n = 0; n < 4; n++) begin
         d       = acc[n] - acc_min;
         pm_d[n] = (d > PM_MAX) ? '1 : d[PM_W-1:0];
      end
   end

   // Non-zero states start biased so decoding assumes the encoder began in state 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < 4; n++) begin
            pm_q[n]   <= (n == 0) ? '0 : PM_W'(4);
            surv_q[n] <= '0;
         end
         cnt_q       <= '0;
         dec_d_o     <= 1'b0;
         dec_valid_o <= 1'b0;
      end else begin
         dec_valid_o <= dec_enable_i && (cnt_q >= FULL - CNT_W'(1));
         if (dec_enable_i) begin
            pm_q    <= pm_d;
            surv_q  <= surv_d;
            cnt_q   <= (cnt_q == FULL) ? cnt_q : cnt_q + CNT_W'(1);
            dec_d_o <= surv_d[best][TB_DEPTH-1];
         end
      end
   end
endmodule

// File: tb/tb_conv_viterbi_codec.sv
// tb_conv_viterbi_codec: encoder vectors plus encoder->channel->decoder loopback with errors, gaps and reset
module tb_conv_viterbi_codec;
  localparam int TB_DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enc_enable_i = 1'b0;
  logic enc_d_i = 1'b0;
  logic enc_valid_o;
  logic [1:0] enc_d_o;
  logic dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic dec_valid_o;
  logic dec_d_o;
  int checks = 0;
  int errors = 0;
  logic expq [$];
  int out_idx = 0, acc_cnt = 0, chan_cnt = 0, err_period = 0, err_at = -1;
  logic [1:0] rs = 2'b00, ref_enc = 2'b00, flip;
  logic pen = 1'b0, pden = 1'b0, last_dec = 1'b0;
  logic [7:0] pmin;
  logic [1:0] vec_exp [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic vec_in [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic done = 1'b0;

  always #5 clk = ~clk;

  conv_viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .enc_enable_i(enc_enable_i),
    .enc_d_i(enc_d_i),
    .enc_valid_o(enc_valid_o),
    .enc_d_o(enc_d_o),
    .dec_enable_i(dec_enable_i),
    .dec_d_i(dec_d_i),
    .dec_valid_o(dec_valid_o),
    .dec_d_o(dec_d_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst();
    checks++;
    if (enc_valid_o !== 1'b0 || enc_d_o !== 2'b00 || dec_valid_o !== 1'b0 || dec_d_o !== 1'b0 ||
        dut.pm_q[0] !== 8'd0 || dut.pm_q[3] !== 8'd4) begin
      errors++;
      $error("FAIL reset state: enc_valid %0b enc_d %0h dec_valid %0b dec_d %0b pm0 %0d pm3 %0d",
             enc_valid_o, enc_d_o, dec_valid_o, dec_d_o, dut.pm_q[0], dut.pm_q[3]);
    end
  endtask

  task automatic cyc(input logic e, input logic b);
    @(negedge clk);
    chk("enc_valid", enc_valid_o, pen);
    chk("enc_d", enc_d_o, ref_enc);
    if (pden && acc_cnt >= TB_DEPTH) begin
      chk("dec_valid", dec_valid_o, 1'b1);
      chk("dec_d", dec_d_o, expq[out_idx]);
      last_dec = expq[out_idx];
      out_idx++;
    end else begin
      chk("dec_valid_low", dec_valid_o, 1'b0);
      chk("dec_hold", dec_d_o, last_dec);
    end
    pmin = dut.pm_q[0];
    for (int k = 1; k < 4; k++) if (dut.pm_q[k] < pmin) pmin = dut.pm_q[k];
    chk("pm_min", pmin, 8'd0);
    flip = 2'b00;
    if (enc_valid_o && err_period > 0 && chan_cnt % err_period == err_period - 1) flip = 2'b10;
    if (enc_valid_o && chan_cnt == err_at) flip = 2'b11;
    dec_enable_i = enc_valid_o;
    dec_d_i = enc_d_o ^ flip;
    if (enc_valid_o) begin
      chan_cnt++;
      acc_cnt++;
    end
    pden = enc_valid_o;
    enc_enable_i = e;
    enc_d_i = b;
    pen = e;
    if (e) begin
      ref_enc = {b ^ rs[0] ^ rs[1], b ^ rs[1]};
      rs = {rs[0], b};
      expq.push_back(b);
    end
  endtask

  task automatic do_reset(input logic keep_en);
    @(negedge clk);
    rst = 1'b1;
    enc_enable_i = keep_en;
    enc_d_i = keep_en;
    dec_enable_i = keep_en;
    dec_d_i = {keep_en, keep_en};
    @(negedge clk);
    rst = 1'b0;
    enc_enable_i = 1'b0;
    dec_enable_i = 1'b0;
    chk_rst();
    rs = 2'b00;
    ref_enc = 2'b00;
    pen = 1'b0;
    pden = 1'b0;
    last_dec = 1'b0;
    expq.delete();
    out_idx = 0;
    acc_cnt = 0;
    chan_cnt = 0;
  endtask

  task automatic flush();
    repeat (3) cyc(1'b0, 1'b0);
    chk("out_count", out_idx, acc_cnt - TB_DEPTH + 1);
  endtask

  initial begin
    #1000000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  initial begin
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, vec_in[i]);
      @(posedge clk);
      #1;
      chk("vec_sym", enc_d_o, vec_exp[i]);
      chk("vec_valid", enc_valid_o, 1'b1);
    end
    repeat (2) cyc(1'b0, 1'b0);
    do_reset(1'b0);
    repeat (256) cyc(1'b1, 1'($urandom_range(0, 1)));
    flush();
    do_reset(1'b0);
    err_period = 8;
    repeat (256) cyc(1'b1, 1'($urandom_range(0, 1)));
    flush();
    err_period = 0;
    do_reset(1'b0);
    repeat (300) cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    flush();
    do_reset(1'b0);
    err_at = 20;
    repeat (64) cyc(1'b1, 1'b0);
    flush();
    err_at = -1;
    do_reset(1'b0);
    repeat (100) cyc(1'b1, 1'($urandom_range(0, 1)));
    do_reset(1'b1);
    repeat (100) cyc(1'b1, 1'($urandom_range(0, 1)));
    flush();
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
